// File: rtl/mcpu_core_sb_pkg.sv
// Shared definitions for the counting register/predicate scoreboard.
// Lane vectors are zero-padded to MAX_LANES before reaching the helpers.
package mcpu_core_sb_pkg;

    localparam int RIDX_W     = 5;
    localparam int LANES_DEF  = 4;
    localparam int NREGS_DEF  = 32;
    localparam int NPREDS_DEF = 3;
    localparam int CNT_W_DEF  = 3;

    // Upper bound on lanes; INC_W must hold a count of 0..MAX_LANES
    localparam int MAX_LANES  = 8;
    localparam int INC_W      = 4;

    function automatic logic [1:0] pred_idx(input logic [RIDX_W-1:0] rd_num);
        return rd_num[1:0];
    endfunction

    function automatic logic [INC_W-1:0] count_lanes(
        input logic [MAX_LANES*RIDX_W-1:0] rd_num,
        input logic [MAX_LANES-1:0]        we,
        input logic                        is_pred,
        input logic [RIDX_W-1:0]           target
    );
        logic [INC_W-1:0] n;
        logic             hit;
        n = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            if (is_pred) begin
                hit = (pred_idx(rd_num[k*RIDX_W +: RIDX_W]) == target[1:0]);
            end else begin
                hit = (rd_num[k*RIDX_W +: RIDX_W] == target);
            end
            if (we[k] && hit) begin
                n = n + INC_W'(1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/mcpu_core_sb_cnt_entry.sv
// One pending-write counter: saturating update, busy/full flags and a
// sticky error bit that latches any clamp.
module mcpu_core_sb_cnt_entry
    import mcpu_core_sb_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic             clkrst_core_clk,
    input  logic             clkrst_core_rst_n,
    input  logic [INC_W-1:0] inc,
    input  logic [INC_W-1:0] dec,
    input  logic [INC_W-1:0] sq,
    output logic             busy,
    output logic             full,
    output logic             err
);

    localparam int SW      = CNT_W + 2;
    localparam int FULL_TH = (1 << CNT_W) - 1 - LANES;

    logic [CNT_W-1:0]     cnt_q;
    logic                 err_q;
    logic signed [SW-1:0] sum;
    logic [SW-1:0]        remain;
    logic                 under;
    logic                 over;
    logic [CNT_W-1:0]     cnt_next;

    // Two guard bits: the sign bit flags underflow, bit CNT_W flags overflow
    always_comb begin
        sum      = SW'(cnt_q) + SW'(inc) - SW'(dec) - SW'(sq);
        under    = sum[SW-1];
        over     = !sum[SW-1] && sum[CNT_W];
        cnt_next = sum[CNT_W-1:0];
        if (under) begin
            cnt_next = '0;
        end else if (over) begin
            cnt_next = '1;
        end
    end

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_next;
            if (under || over) begin
                err_q <= 1'b1;
            end
        end
    end

    // Busy looks through this cycle's writeback so it drops one cycle after wb
    always_comb begin
        remain = SW'(cnt_q) - SW'(dec);
        busy   = (remain != '0);
        full   = (int'(cnt_q) > FULL_TH);
    end

    assign err = err_q;

endmodule

// File: rtl/mcpu_core_scoreboard_cnt.sv
// Counting GPR/predicate scoreboard between decode and writeback; entries
// 0..NREGS-1 are GPRs, the remaining NPREDS entries are predicates.
module mcpu_core_scoreboard_cnt
    import mcpu_core_sb_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NPREDS = NPREDS_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clkrst_core_clk,
    input  logic                    clkrst_core_rst_n,
    input  logic [LANES*RIDX_W-1:0] d2pc_out_rd_num,
    input  logic [LANES-1:0]        d2pc_out_rd_we,
    input  logic [LANES-1:0]        d2pc_out_pred_we,
    input  logic                    d2pc_progress,
    input  logic                    pipe_flush,
    input  logic                    exception,
    input  logic [LANES*RIDX_W-1:0] wb2rf_rd_num,
    input  logic [LANES-1:0]        wb2rf_rd_we,
    input  logic [LANES-1:0]        wb2rf_pred_we,
    output logic [NREGS-1:0]        sb2d_reg_scoreboard,
    output logic [NPREDS-1:0]       sb2d_pred_scoreboard,
    output logic [NREGS-1:0]        sb2d_reg_full,
    output logic [NPREDS-1:0]       sb2d_pred_full,
    output logic                    sb_err
);

    localparam int NENT = NREGS + NPREDS;

    logic [LANES*RIDX_W-1:0]     wb_rd_num_q;
    logic [LANES-1:0]            wb_rd_we_q;
    logic [LANES-1:0]            wb_pred_we_q;

    logic [MAX_LANES*RIDX_W-1:0] iss_rd_pad;
    logic [MAX_LANES-1:0]        iss_gpr_we_pad;
    logic [MAX_LANES-1:0]        iss_pred_we_pad;
    logic [MAX_LANES*RIDX_W-1:0] wb_rd_pad;
    logic [MAX_LANES-1:0]        wb_gpr_we_pad;
    logic [MAX_LANES-1:0]        wb_pred_we_pad;

    logic [INC_W-1:0] inc_raw  [NENT];
    logic [INC_W-1:0] inc_app  [NENT];
    logic [INC_W-1:0] dec      [NENT];
    logic [INC_W-1:0] sq       [NENT];
    logic [INC_W-1:0] last_inc [NENT];

    logic [NENT-1:0] busy;
    logic [NENT-1:0] full;
    logic [NENT-1:0] err;

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            wb_rd_num_q  <= '0;
            wb_rd_we_q   <= '0;
            wb_pred_we_q <= '0;
        end else begin
            wb_rd_num_q  <= wb2rf_rd_num;
            wb_rd_we_q   <= wb2rf_rd_we;
            wb_pred_we_q <= wb2rf_pred_we;
        end
    end

    // Flushed lanes still count as issued, but contribute zero increments
    always_comb begin
        iss_rd_pad      = '0;
        iss_gpr_we_pad  = '0;
        iss_pred_we_pad = '0;
        wb_rd_pad       = '0;
        wb_gpr_we_pad   = '0;
        wb_pred_we_pad  = '0;
        iss_rd_pad[LANES*RIDX_W-1:0] = d2pc_out_rd_num;
        iss_gpr_we_pad[LANES-1:0]    = d2pc_out_rd_we & ~{LANES{pipe_flush}};
        iss_pred_we_pad[LANES-1:0]   = d2pc_out_pred_we & ~{LANES{pipe_flush}};
        wb_rd_pad[LANES*RIDX_W-1:0]  = wb_rd_num_q;
        wb_gpr_we_pad[LANES-1:0]     = wb_rd_we_q;
        wb_pred_we_pad[LANES-1:0]    = wb_pred_we_q;
    end

    for (genvar i = 0; i < NENT; i++) begin : g_ent
        localparam logic              IS_PRED = (i >= NREGS);
        localparam logic [RIDX_W-1:0] TGT     = IS_PRED ? RIDX_W'(i - NREGS) : RIDX_W'(i);

        assign inc_raw[i] = count_lanes(iss_rd_pad, IS_PRED ? iss_pred_we_pad : iss_gpr_we_pad,
                                        IS_PRED, TGT);
        assign dec[i]     = count_lanes(wb_rd_pad, IS_PRED ? wb_pred_we_pad : wb_gpr_we_pad,
                                        IS_PRED, TGT);
        assign inc_app[i] = d2pc_progress ? inc_raw[i] : '0;
        assign sq[i]      = exception ? last_inc[i] : '0;

        // Remembers the most recent bundle so an exception can undo it
        always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
            if (!clkrst_core_rst_n) begin
                last_inc[i] <= '0;
            end else if (d2pc_progress) begin
                last_inc[i] <= inc_raw[i];
            end
        end

        mcpu_core_sb_cnt_entry #(
            .CNT_W (CNT_W),
            .LANES (LANES)
        ) u_entry (
            .clkrst_core_clk   (clkrst_core_clk),
            .clkrst_core_rst_n (clkrst_core_rst_n),
            .inc               (inc_app[i]),
            .dec               (dec[i]),
            .sq                (sq[i]),
            .busy              (busy[i]),
            .full              (full[i]),
            .err               (err[i])
        );
    end

    assign sb2d_reg_scoreboard  = busy[NREGS-1:0];
    assign sb2d_pred_scoreboard = busy[NENT-1:NREGS];
    assign sb2d_reg_full        = full[NREGS-1:0];
    assign sb2d_pred_full       = full[NENT-1:NREGS];
    assign sb_err               = |err;

endmodule

// File: doc/mcpu_core_scoreboard_cnt.md
Name: mcpu_core_scoreboard_cnt

Overview:
- Parametrised successor of the core's register/predicate scoreboard. Sits between decode and writeback.
- Tracks outstanding writes with a per-entry pending counter instead of a single bit. This lets several in-flight writes target the same GPR or predicate, as needed by variable-latency units.
- Decode reads the busy masks to stall RAW/WAW hazards, and the full masks to stall before counter overflow.
- Exception squash of the most recent issued bundle is retained. A sticky error flag is added for verification.

Parameters:
- LANES, 4, issue/writeback lanes per bundle.
- NREGS, 32, GPRs tracked.
- NPREDS, 3, predicate registers tracked.
- CNT_W, 3, pending-counter width per entry.
- RIDX_W, 5, register index width (clog2(NREGS)).

Ports:
- clkrst_core_clk  in  1  core clock
- clkrst_core_rst_n  in  1  async active-low reset
- d2pc_out_rd_num  in  LANES*RIDX_W  per-lane destination index; lane k at [k*RIDX_W +: RIDX_W]
- d2pc_out_rd_we  in  LANES  per-lane GPR write enable
- d2pc_out_pred_we  in  LANES  per-lane predicate write enable; predicate index = rd_num[1:0]
- d2pc_progress  in  1  bundle issued this cycle
- pipe_flush  in  1  suppress issue increments this cycle
- exception  in  1  squash the last issued bundle
- wb2rf_rd_num  in  LANES*RIDX_W  writeback indices
- wb2rf_rd_we  in  LANES  writeback GPR enables
- wb2rf_pred_we  in  LANES  writeback predicate enables
- sb2d_reg_scoreboard  out  NREGS  busy: counter != 0
- sb2d_pred_scoreboard  out  NPREDS  busy: counter != 0
- sb2d_reg_full  out  NREGS  counter > 2^CNT_W-1-LANES
- sb2d_pred_full  out  NPREDS  same rule for predicates
- sb_err  out  1  sticky overflow/underflow flag

Behaviour:
- Clock and reset: one clock, clkrst_core_clk. Reset clkrst_core_rst_n is asynchronous and active-low.
- Reset state: all counters 0, last-bundle increments 0, wb pipeline regs 0, sb_err 0. All outputs are therefore 0.
- Per-lane decode: GPR one-hot over NREGS; predicate one-hot over NPREDS from rd_num[1:0]. A predicate index >= NPREDS (value 3) contributes nothing.
- Increment vector inc[i] = number of lanes with (we & ~pipe_flush) targeting entry i, range 0..LANES. It applies only when d2pc_progress=1.
- Writeback timing:
  - wb inputs are registered one cycle (wb_q); dec[i] = number of valid wb_q lanes targeting entry i.
  - The busy output is combinational: the registered counter minus dec, compared != 0. A writeback at cycle t therefore clears busy in cycle t+1, matching the previous scoreboard's timing.
- Last-bundle capture: on d2pc_progress, last_inc <= inc (including zeros under pipe_flush). Otherwise last_inc holds.
- Squash: sq[i] = exception ? last_inc[i] : 0.
- Counter update: cnt_next = cnt + (progress ? inc : 0) - dec - sq, evaluated at width CNT_W+2 signed.
  - Result < 0: clamp to 0, set sb_err.
  - Result > 2^CNT_W-1: clamp to max, set sb_err.
- Simultaneous events:
  - progress + exception in the same cycle: the squash uses the previous last_inc and the new inc is still added.
  - Writeback and squash of the same entry both subtract; underflow clamps and flags.
- Full masks come from the registered counter, not cnt_next. Decode must not issue a write to a full entry; doing so is a decode bug and sb_err catches it.
- sb_err clears only on reset.
- Reset mid-operation clears everything asynchronously. In-flight writebacks arriving after reset underflow and set sb_err. The core must flush the pipe on reset, so this is legal only in test.
- No combinational path from the d2pc_* inputs to any output.

Decomposition:
- Shared package mcpu_core_sb_pkg holds: RIDX_W, default LANES/NREGS/NPREDS/CNT_W, the predicate-index function, and a popcount-of-matching-lanes function.
- One natural sub-module: mcpu_core_sb_cnt_entry. It is one counter with inputs inc/dec/sq and outputs busy/full/err, instantiated NREGS+NPREDS times via generate.

Test Plan:
1. Reset, then progress with lane0 writing r5 -> next cycle reg_scoreboard=0x20. Writeback r5 -> busy r5 drops exactly one cycle after wb2rf_rd_we.
2. Two bundles, each writing r7 (counter 2), then one writeback -> r7 still busy; second writeback -> r7 clear, sb_err=0.
3. Bundle with all 4 lanes writing r3 -> counter 4, sb2d_reg_full[3]=1 (threshold >3).
4. Issue r9 and p1, then exception the next cycle -> r9 and p1 clear. An earlier outstanding r4 stays busy.
5. progress with pipe_flush=1 writing r2 -> no busy, last_inc=0. A following exception changes nothing.
6. Writeback r10 with counter 0 -> counter stays 0, sb_err=1 and it remains 1 until clkrst_core_rst_n=0.
